// File: rtl/demux_pkg.sv
// Shared types and lane bit-placement helper for the demux_lanes block.
package demux_pkg;

   typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} demux_state_t;
   typedef enum logic {MODE_DIRECT = 1'b0, MODE_RR = 1'b1} demux_mode_t;

   // Lane 0 sits in the MSBs of the output frame.
   function automatic int lane_slice_msb(input int k, input int nb_lanes, input int data_w);
      return (nb_lanes - k) * data_w - 1;
   endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One lane of the demultiplexer: a data word plus its fill flag.
module demux_lane_reg
   import demux_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] q,
   output logic              valid
);

   // A load wins over a clear so a frame restart can write its first word.
   always_ff @(posedge clk) begin
      if (reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= data;
         valid <= 1'b1;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_lanes.sv
// 1:NB_LANES sequential demultiplexer with direct and round-robin lane routing.
// Define DEMUX_LANES_PARITY_EN to add the per-lane even-parity output outParity.
//
// state   | meaning
// ST_FILL | collecting one word per lane, inReady high
// ST_HOLD | frame complete, outValid high, waiting for outReady
module demux_lanes
   import demux_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int NB_LANES = 2,
   parameter int LANE_W   = $clog2(NB_LANES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          inData,
   input  logic                       inValid,
   output logic                       inReady,
   input  logic [LANE_W-1:0]          inSel,
   input  logic                       inMode,
   input  logic                       inFlush,
   output logic [NB_LANES*DATA_W-1:0] outData,
   output logic [NB_LANES-1:0]        outLaneValid,
   output logic                       outValid,
`ifdef DEMUX_LANES_PARITY_EN
   output logic [NB_LANES-1:0]        outParity,
`endif
   input  logic                       outReady
);

   demux_state_t      state;
   demux_mode_t       mode_q;
   logic [LANE_W-1:0] wr_ptr;
   logic [LANE_W-1:0] eff_ptr;
   logic [LANE_W-1:0] lane_idx;
   logic [LANE_W-1:0] ptr_next;
   logic [NB_LANES-1:0] load_vec;
   logic [NB_LANES-1:0] clear_vec;
   logic [NB_LANES-1:0] valid_next;
   logic              fill;
   logic              accept;
   logic              take;
   logic              mode_chg;
   logic              sel_ok;
   logic [DATA_W-1:0] lane_q [NB_LANES];

   assign fill     = (state == ST_FILL);
   assign inReady  = fill & ~reset;
   assign outValid = (state == ST_HOLD);
   assign accept   = inValid & inReady;
   assign take     = accept & ~inFlush;

   // Switching mode mid-frame restarts the frame; the same-cycle word opens the new one.
   assign mode_chg = fill & (demux_mode_t'(inMode) != mode_q) & (|outLaneValid);
   assign eff_ptr  = mode_chg ? '0 : wr_ptr;
   assign lane_idx = inMode ? eff_ptr : inSel;
   assign sel_ok   = ({1'b0, lane_idx} < (LANE_W+1)'(NB_LANES));
   assign ptr_next = (eff_ptr == LANE_W'(NB_LANES - 1)) ? '0 : eff_ptr + LANE_W'(1);

   always_comb begin
      load_vec  = '0;
      clear_vec = '0;
      for (int k = 0; k < NB_LANES; k++) begin
         load_vec[k] = take & sel_ok & (lane_idx == LANE_W'(k));
      end
      if (fill & (inFlush | mode_chg)) clear_vec = '1;
      if (outValid & outReady)         clear_vec = '1;
   end

   assign valid_next = (mode_chg ? '0 : outLaneValid) | load_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_FILL;
         mode_q <= MODE_DIRECT;
         wr_ptr <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               mode_q <= demux_mode_t'(inMode);
               if (inFlush)
                  wr_ptr <= '0;
               else if (take & inMode)
                  wr_ptr <= ptr_next;
               else
                  wr_ptr <= eff_ptr;
               if (take & (&valid_next)) state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (outReady) begin
                  wr_ptr <= '0;
                  state  <= ST_FILL;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

   for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
      demux_lane_reg #(.DATA_W(DATA_W)) u_lane (
         .clk   (clk),
         .reset (reset),
         .load  (load_vec[k]),
         .clear (clear_vec[k]),
         .data  (inData),
         .q     (lane_q[k]),
         .valid (outLaneValid[k])
      );

      assign outData[lane_slice_msb(k, NB_LANES, DATA_W) -: DATA_W] = lane_q[k];

`ifdef DEMUX_LANES_PARITY_EN
      always_ff @(posedge clk) begin
         if (reset)
            outParity[k] <= 1'b0;
         else if (load_vec[k])
            outParity[k] <= ^inData;
      end
`endif
   end

endmodule

// File: doc/demux_lanes.md
Name: demux_lanes

Overview:
- Parametrised, sequential 1:NB_LANES demultiplexer that splits a DATA_W-bit chip/symbol stream into NB_LANES parallel lanes, for example the I/Q split ahead of the O-QPSK modulator.
- Collects one word per lane, then presents the aligned frame on a registered output with a valid/ready handshake.
- Two routing modes: direct (lane chosen by inSel) and round-robin (lane chosen by an internal write pointer).

Parameters:
- DATA_W, 4, width of one lane word.
- NB_LANES, 2, number of output lanes (>=2).
- LANE_W, $clog2(NB_LANES), width of the lane index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- inData  in  DATA_W  input word.
- inValid  in  1  inData is valid.
- inReady  out  1  block accepts a word this cycle.
- inSel  in  LANE_W  target lane in direct mode; ignored in round-robin mode.
- inMode  in  1  0 = direct, 1 = round-robin.
- inFlush  in  1  discard the partial frame.
- outData  out  NB_LANES*DATA_W  frame; lane 0 in the MSBs, lane k at bits [(NB_LANES-k)*DATA_W-1 -: DATA_W].
- outLaneValid  out  NB_LANES  per-lane fill status (bit k = lane k written).
- outValid  out  1  frame complete and held.
- outReady  in  1  consumer takes the frame.

Behaviour:
- Reset values (synchronous): state=ST_FILL, lane registers=0, outData=0, outLaneValid=0, outValid=0, wrPtr=0, latched mode=0. inReady=0 while reset is high.
- inReady = (state==ST_FILL) & ~reset. outValid = (state==ST_HOLD). Both are decoded from registered state.
- Accept occurs when inValid & inReady.
- ST_FILL accept:
  - Lane index = inSel in direct mode, wrPtr in round-robin mode.
  - Write inData to the selected lane and set its outLaneValid bit.
  - Round-robin: wrPtr <= (wrPtr==NB_LANES-1) ? 0 : wrPtr+1.
- Direct-mode duplicate: a write to an already-valid lane overwrites the data; the valid bit stays set.
- Direct mode with inSel >= NB_LANES (non-power-of-2 NB_LANES): word dropped; the accept still completes the handshake.
- Frame complete: when the accept makes all outLaneValid bits 1, state goes to ST_HOLD on the next edge. outValid is asserted 1 cycle after the completing accept.
- ST_HOLD:
  - outData and outLaneValid are frozen; inValid is ignored.
  - On outReady: outLaneValid <= 0, wrPtr <= 0, state <= ST_FILL. Lane data registers keep their old contents.
- Throughput: NB_LANES+1 cycles per frame minimum.
- inFlush:
  - In ST_FILL: outLaneValid <= 0 and wrPtr <= 0. Flush has priority over a simultaneous accept (that word is dropped).
  - In ST_HOLD: ignored.
- Mode change: a change of inMode while in ST_FILL with any outLaneValid bit set acts as an implicit flush. The word accepted in that same cycle is then written as the first word of a new frame in the new mode.
- reset has priority over everything, including mid-frame and during ST_HOLD.

Optional Feature:
- Macro: DEMUX_LANES_PARITY_EN.
- Defined:
  - Extra output port outParity (NB_LANES): bit k = even parity (XOR reduction) of lane k, registered on the same edge as the lane write.
  - Reset value 0; frozen in ST_HOLD.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package demux_pkg:
  - typedef enum logic {ST_FILL, ST_HOLD} demux_state_t.
  - typedef enum logic {MODE_DIRECT=1'b0, MODE_RR=1'b1} demux_mode_t.
  - Function lane_slice_msb(k, NB_LANES, DATA_W) for output bit placement.
- Sub-module demux_lane_reg: one DATA_W register plus valid bit, with load and clear inputs and synchronous reset; instantiated NB_LANES times in a generate loop.
- Top level holds the FSM, wrPtr, mode latch and flush logic.

Test Plan:
- DATA_W=4, NB_LANES=2, RR: accept 0xA then 0x5 -> outValid=1 one cycle after second accept, outData=8'hA5; outReady=1 -> next cycle outValid=0, outLaneValid=2'b00, inReady=1.
- Direct: inSel=1 data 0x3, then inSel=0 data 0xC -> outData=8'hC3.
- Direct: sel0 0x1, sel0 0x7, sel1 0x2 -> outData=8'h72.
- Backpressure: frame 8'hA5 held with outReady=0 for 5 cycles and inValid=1 inData=0xF -> inReady=0 throughout, outData stays 8'hA5.
- Flush/mode: RR accept 0x9, pulse inFlush, accept 0x4, 0x6 -> 8'h46. RR accept 0x9, switch inMode=0 with inSel=1 data 0x2, then sel0 0xB -> 8'hB2.
- NB_LANES=4, RR: 1,2,3,4 -> outData=16'h1234. Assert reset during ST_HOLD -> next cycle outValid=0, outData=0, outLaneValid=0. With DEMUX_LANES_PARITY_EN, data 0x7,0x3,0x0,0x1 -> outParity=4'b1001.
